stopwatch_count: RTL and testbench
==================================

STOPWATCH_COUNT -- requirements
Module: stopwatch_count

Interface
REQ-001 Parameter SCAN_BITS, default 16: width of the display-scan prescaler; the digit select advances every 2^SCAN_BITS clk_base cycles.
REQ-002 clk_base  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk_base.
REQ-004 tick_in  input  1  divided timebase from the upstream pause/divider stage; one rising edge = one second.
REQ-005 clear  input  1  synchronous zero of the time count; level-sensitive.
REQ-006 digits  output  16  registered BCD time {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
REQ-007 rollover  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap.
REQ-008 an  output  4  registered active-low digit enables; bit 0 = sec_ones.
REQ-009 seg  output  7  registered active-low segments {g,f,e,d,c,b,a} for the enabled digit.

Function
REQ-010 tick_in shall be treated as asynchronous to the count logic and detected by a previous-value register; a tick event is tick_in=1 while the previous value is 0.
REQ-011 The previous-value register shall reset to 1, matching the upstream clk_out reset level, so no tick event occurs in the cycle after reset.
REQ-012 digits shall update in the cycle after the edge is sampled, with latency 1 clk_base from the sampled tick_in rise.
REQ-013 Count order: sec_ones 0-9; sec_tens 0-5; min_ones 0-9; min_tens 0-5. Each carry ripples in the same cycle.
REQ-014 At 59:59 a tick event shall produce 00:00 and assert rollover for exactly that one cycle.
REQ-015 clear=1 shall set digits to 0000 on the next edge and shall override a simultaneous tick event; rollover shall stay 0.
REQ-016 While clear=1, edge detection shall continue, so a tick_in rise during clear is consumed and not replayed later.
REQ-017 tick_in held constant (upstream paused) shall cause no change to digits, at any level and for any duration.
REQ-018 A SCAN_BITS-bit prescaler shall free-run from reset and wrap at all-ones.
REQ-019 On each prescaler wrap, a 2-bit digit select shall advance 0->1->2->3->0.
REQ-020 an shall be 1110, 1101, 1011 or 0111 for select 0, 1, 2 or 3; exactly one bit shall be low at all times.
REQ-021 seg shall be the decode of the selected digit, registered in the same cycle as an so the two never disagree.
REQ-022 seg codes for 0-9 (gfedcba, active-low): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-023 Any BCD value above 9 shall decode to seg = 1111111 (blank); such a value is unreachable in normal operation.
REQ-024 The display path shall reflect the current digits value, with no latching beyond the single output register.

Reset
REQ-025 reset=1 shall set digits=0000, rollover=0, prescaler=0, select=0, an=1110, seg=1000000 and previous tick_in=1, all on the next edge.
REQ-026 reset shall take priority over clear and over tick events.
REQ-027 A reset asserted mid-count shall discard the count; the first tick event after release shall yield 00:01.

Structure
REQ-028 The shared stopwatch package shall hold the BCD limits (9, 5), the seg code constants and the anode patterns.
REQ-029 One sub-module, seg7_decode, shall be used: a combinational mapping of 4-bit BCD to 7-bit active-low seg, instantiated once on the selected digit.
REQ-030 The counter and scan logic shall remain in stopwatch_count; no other hierarchy is required.

Verification (SCAN_BITS=2 for the bench)
REQ-031 Reset, then 10 tick_in rises -> digits=0010; seg/an show 0,1,0,0 across the scan cycle.
REQ-032 Preload by 3599 ticks, then one more tick -> digits=0000 and rollover high for exactly 1 cycle.
REQ-033 tick_in rise in the same cycle as clear=1 at 00:42 -> digits=0000, no 00:01 afterwards, rollover=0.
REQ-034 tick_in held 1 then held 0 for 1000 cycles each -> digits unchanged; scan continues with an every 4 cycles.
REQ-035 Reset released while tick_in=1, with no further edges -> digits stays 0000.
REQ-036 reset asserted at 12:34 while a tick event is in progress -> all outputs equal the REQ-025 values on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: BCD limits, seven-segment codes and
// digit-select / anode patterns.
package stopwatch_pkg;

   localparam logic [3:0] BCD_ONES_MAX = 4'd9;
   localparam logic [3:0] BCD_TENS_MAX = 4'd5;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_SEC_ONES = 4'b1110;
   localparam logic [3:0] AN_SEC_TENS = 4'b1101;
   localparam logic [3:0] AN_MIN_ONES = 4'b1011;
   localparam logic [3:0] AN_MIN_TENS = 4'b0111;

   typedef enum logic [1:0] {
      DIG_SEC_ONES = 2'd0,
      DIG_SEC_TENS = 2'd1,
      DIG_MIN_ONES = 2'd2,
      DIG_MIN_TENS = 2'd3
   } digit_sel_e;

   function automatic logic [3:0] anode_of(digit_sel_e sel);
      anode_of = AN_SEC_ONES;
      case (sel)
         DIG_SEC_ONES: anode_of = AN_SEC_ONES;
         DIG_SEC_TENS: anode_of = AN_SEC_TENS;
         DIG_MIN_ONES: anode_of = AN_MIN_ONES;
         DIG_MIN_TENS: anode_of = AN_MIN_TENS;
         default:      anode_of = AN_SEC_ONES;
      endcase
   endfunction

   function automatic digit_sel_e next_sel(digit_sel_e sel);
      next_sel = DIG_SEC_ONES;
      case (sel)
         DIG_SEC_ONES: next_sel = DIG_SEC_TENS;
         DIG_SEC_TENS: next_sel = DIG_MIN_ONES;
         DIG_MIN_ONES: next_sel = DIG_MIN_TENS;
         DIG_MIN_TENS: next_sel = DIG_SEC_ONES;
         default:      next_sel = DIG_SEC_ONES;
      endcase
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decode; values above 9 blank.
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/stopwatch_count.sv
// MM:SS BCD stopwatch counter driven by an edge-detected tick, with a
// multiplexed four-digit seven-segment scan.
module stopwatch_count
   import stopwatch_pkg::*;
#(
   parameter int unsigned SCAN_BITS = 16
) (
   input  logic        clk_base,
   input  logic        reset,
   input  logic        tick_in,
   input  logic        clear,
   output logic [15:0] digits,
   output logic        rollover,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   logic                 tick_prev_q;
   logic                 tick_evt;
   logic [15:0]          digits_q, digits_d;
   logic                 rollover_q, rollover_d;
   logic [SCAN_BITS-1:0] scan_q, scan_d;
   digit_sel_e           sel_q, sel_d;
   logic [3:0]           an_q;
   logic [6:0]           seg_q;
   logic [3:0]           shown_digit;
   logic [6:0]           seg_dec;
   logic [3:0]           so_d, st_d, mo_d, mt_d;

   // Previous value resets high so a tick_in already high at release is not an edge
   assign tick_evt = tick_in & ~tick_prev_q;

   always_comb begin
      so_d       = digits_q[3:0];
      st_d       = digits_q[7:4];
      mo_d       = digits_q[11:8];
      mt_d       = digits_q[15:12];
      rollover_d = 1'b0;
      if (clear) begin
         so_d = '0;
         st_d = '0;
         mo_d = '0;
         mt_d = '0;
      end else if (tick_evt) begin
         if (digits_q[3:0] != BCD_ONES_MAX) begin
            so_d = digits_q[3:0] + 4'd1;
         end else begin
            so_d = '0;
            if (digits_q[7:4] != BCD_TENS_MAX) begin
               st_d = digits_q[7:4] + 4'd1;
            end else begin
               st_d = '0;
               if (digits_q[11:8] != BCD_ONES_MAX) begin
                  mo_d = digits_q[11:8] + 4'd1;
               end else begin
                  mo_d = '0;
                  if (digits_q[15:12] != BCD_TENS_MAX) begin
                     mt_d = digits_q[15:12] + 4'd1;
                  end else begin
                     mt_d       = '0;
                     rollover_d = 1'b1;
                  end
               end
            end
         end
      end
      digits_d = {mt_d, mo_d, st_d, so_d};
   end

   always_comb begin
      scan_d = scan_q + 1'b1;
      sel_d  = (scan_q == '1) ? next_sel(sel_q) : sel_q;
   end

   always_comb begin
      shown_digit = digits_q[3:0];
      case (sel_q)
         DIG_SEC_ONES: shown_digit = digits_q[3:0];
         DIG_SEC_TENS: shown_digit = digits_q[7:4];
         DIG_MIN_ONES: shown_digit = digits_q[11:8];
         DIG_MIN_TENS: shown_digit = digits_q[15:12];
         default:      shown_digit = digits_q[3:0];
      endcase
   end

   seg7_decode u_seg7_decode (
      .bcd_i (shown_digit),
      .seg_o (seg_dec)
   );

   // an and seg load from the same select in the same cycle, so they always agree
   always_ff @(posedge clk_base) begin
      if (reset) begin
         tick_prev_q <= 1'b1;
         digits_q    <= '0;
         rollover_q  <= 1'b0;
         scan_q      <= '0;
         sel_q       <= DIG_SEC_ONES;
         an_q        <= AN_SEC_ONES;
         seg_q       <= SEG_0;
      end else begin
         tick_prev_q <= tick_in;
         digits_q    <= digits_d;
         rollover_q  <= rollover_d;
         scan_q      <= scan_d;
         sel_q       <= sel_d;
         an_q        <= anode_of(sel_q);
         seg_q       <= seg_dec;
      end
   end

   assign digits   = digits_q;
   assign rollover = rollover_q;
   assign an       = an_q;
   assign seg      = seg_q;

endmodule

// File: tb/tb_stopwatch_count.sv
// Self-checking bench for stopwatch_count: seconds-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_stopwatch_count;

   localparam int unsigned SCAN_BITS   = 2;
   localparam int unsigned SCAN_PERIOD = 1 << SCAN_BITS;

   logic        clk_base = 1'b0;
   logic        reset    = 1'b1;
   logic        tick_in  = 1'b0;
   logic        clear    = 1'b0;
   logic [15:0] digits;
   logic        rollover;
   logic [3:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int errors = 0;

   stopwatch_count #(.SCAN_BITS(SCAN_BITS)) dut (
      .clk_base (clk_base),
      .reset    (reset),
      .tick_in  (tick_in),
      .clear    (clear),
      .digits   (digits),
      .rollover (rollover),
      .an       (an),
      .seg      (seg)
   );

   always #5 clk_base = ~clk_base;

   function automatic logic [15:0] to_bcd(int s);
      int m;
      int sec;
      m   = s / 60;
      sec = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   function automatic logic [6:0] seg_code(logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: elapsed seconds as an integer, scan position from
   // the number of clocks since reset.
   int         m_secs = 0;
   int         m_cyc  = 0;
   bit         m_prev = 1'b1;
   bit         m_roll = 1'b0;
   bit         m_valid = 1'b0;
   logic [3:0] m_an  = 4'b1110;
   logic [6:0] m_seg = 7'b1000000;

   always @(posedge clk_base) begin
      if (reset) begin
         m_secs  = 0;
         m_cyc   = 0;
         m_prev  = 1'b1;
         m_roll  = 1'b0;
         m_an    = 4'b1110;
         m_seg   = 7'b1000000;
         m_valid = 1'b1;
      end else begin
         int         sel;
         logic [15:0] b;
         sel   = (m_cyc / SCAN_PERIOD) % 4;
         b     = to_bcd(m_secs);
         m_an  = ~(4'b0001 << sel);
         m_seg = seg_code(b[4*sel +: 4]);
         m_roll = 1'b0;
         if (clear) begin
            m_secs = 0;
         end else if (tick_in && !m_prev) begin
            if (m_secs == 3599) m_roll = 1'b1;
            m_secs = (m_secs + 1) % 3600;
         end
         m_prev = tick_in;
         m_cyc++;
      end
   end

   always @(negedge clk_base) begin
      if (m_valid) begin
         check("model_digits",   digits,   to_bcd(m_secs));
         check("model_rollover", rollover, m_roll);
         check("model_an",       an,       m_an);
         check("model_seg",      seg,      m_seg);
      end
   end

   task automatic cycles(int n);
      repeat (n) @(negedge clk_base);
   endtask

   task automatic do_reset(logic tick_lvl);
      @(negedge clk_base);
      reset   = 1'b1;
      tick_in = tick_lvl;
      clear   = 1'b0;
      @(negedge clk_base);
      reset = 1'b0;
   endtask

   task automatic ticks(int n);
      repeat (n) begin
         @(negedge clk_base);
         tick_in = 1'b1;
         @(negedge clk_base);
         tick_in = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      logic [3:0] seen;
      logic [3:0] prev_an;
      int         changes;

      // Reset state and ten ticks, then one full scan cycle
      do_reset(1'b0);
      check("reset_digits",   digits,   16'h0000);
      check("reset_rollover", rollover, 1'b0);
      check("reset_an",       an,       4'b1110);
      check("reset_seg",      seg,      7'b1000000);
      ticks(10);
      check("ten_ticks", digits, 16'h0010);
      seen = 4'b0000;
      repeat (4 * SCAN_PERIOD) begin
         @(negedge clk_base);
         case (an)
            4'b1110: begin seen[0] = 1'b1; check("scan_d0", seg, 7'b1000000); end
            4'b1101: begin seen[1] = 1'b1; check("scan_d1", seg, 7'b1111001); end
            4'b1011: begin seen[2] = 1'b1; check("scan_d2", seg, 7'b1000000); end
            4'b0111: begin seen[3] = 1'b1; check("scan_d3", seg, 7'b1000000); end
            default: check("scan_an_onehot", an, 4'b1110);
         endcase
      end
      check("scan_all_digits", seen, 4'b1111);

      // Full-range count and wrap
      do_reset(1'b0);
      ticks(3599);
      check("preload_5959", digits, 16'h5959);
      @(negedge clk_base);
      tick_in = 1'b1;
      @(negedge clk_base);
      check("wrap_digits",   digits,   16'h0000);
      check("wrap_rollover", rollover, 1'b1);
      tick_in = 1'b0;
      @(negedge clk_base);
      check("wrap_rollover_drop", rollover, 1'b0);
      check("wrap_digits_hold",   digits,   16'h0000);

      // Clear wins over a coincident tick and the edge is consumed
      do_reset(1'b0);
      ticks(42);
      check("preload_0042", digits, 16'h0042);
      @(negedge clk_base);
      tick_in = 1'b1;
      clear   = 1'b1;
      @(negedge clk_base);
      clear = 1'b0;
      check("clear_digits",   digits,   16'h0000);
      check("clear_rollover", rollover, 1'b0);
      cycles(3);
      tick_in = 1'b0;
      cycles(3);
      check("clear_no_replay", digits, 16'h0000);
      ticks(1);
      check("clear_resume", digits, 16'h0001);

      // Paused timebase at both levels
      do_reset(1'b0);
      ticks(5);
      @(negedge clk_base);
      tick_in = 1'b1;
      cycles(1000);
      check("hold_high", digits, 16'h0006);
      tick_in = 1'b0;
      prev_an = an;
      changes = 0;
      repeat (1000) begin
         @(negedge clk_base);
         if (an != prev_an) changes++;
         prev_an = an;
      end
      check("hold_low", digits, 16'h0006);
      check("scan_rate", changes, 250);

      // Release from reset with tick_in already high
      do_reset(1'b1);
      cycles(20);
      check("release_high", digits, 16'h0000);
      tick_in = 1'b0;
      cycles(2);
      check("release_high_after", digits, 16'h0000);

      // Reset mid-count during a tick event
      do_reset(1'b0);
      ticks(754);
      check("preload_1234", digits, 16'h1234);
      @(negedge clk_base);
      tick_in = 1'b1;
      reset   = 1'b1;
      @(negedge clk_base);
      reset = 1'b0;
      check("midreset_digits",   digits,   16'h0000);
      check("midreset_rollover", rollover, 1'b0);
      check("midreset_an",       an,       4'b1110);
      check("midreset_seg",      seg,      7'b1000000);
      @(negedge clk_base);
      tick_in = 1'b0;
      ticks(1);
      check("midreset_first_tick", digits, 16'h0001);

      cycles(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
